// File: rtl/ysyx_22050039_ifu_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, the {inst, pc} channel
// to decode, and the redirect/flush inputs from the back end.
interface ysyx_22050039_ifu_fetch_if #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
);
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [XLEN-1:0]     mem_req_addr;
  logic                mem_resp_valid;
  logic [INST_LEN-1:0] mem_resp_data;
  logic                inst_valid;
  logic                inst_ready;
  logic [INST_LEN-1:0] inst;
  logic [XLEN-1:0]     pc;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;
  logic                flush_valid;
  logic [XLEN-1:0]     flush_pc;

  // The fetch unit is the master of this bundle.
  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst, pc,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
           redirect_valid, redirect_pc, flush_valid, flush_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst, pc,
    output mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
           redirect_valid, redirect_pc, flush_valid, flush_pc
  );
endinterface

// File: rtl/ysyx_22050039_ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a time,
// and hands {inst, pc} to decode; redirect and flush steer the next PC.
module ysyx_22050039_ifu_fetch #(
  parameter int              XLEN     = 64,
  parameter int              INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_22050039_ifu_fetch_if.master bus
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]          r_state;
  logic [XLEN-1:0]     r_fetch_pc;
  logic [XLEN-1:0]     r_req_addr;
  logic [XLEN-1:0]     r_pc;
  logic [INST_LEN-1:0] r_inst;
  logic                r_kill;
  logic                r_inst_valid;

  logic [XLEN-1:0]     w_flush_pc;
  logic [XLEN-1:0]     w_redirect_pc;
  logic [XLEN-1:0]     w_next_pc;

  // Targets are forced word aligned; the sequential successor wraps naturally.
  assign w_flush_pc    = bus.flush_pc & ~XLEN'(3);
  assign w_redirect_pc = bus.redirect_pc & ~XLEN'(3);
  assign w_next_pc     = bus.redirect_valid ? w_redirect_pc : (r_pc + XLEN'(4));

  assign bus.mem_req_valid = (r_state == S_REQ);
  assign bus.mem_req_addr  = r_req_addr;
  assign bus.inst_valid    = r_inst_valid;
  assign bus.inst          = r_inst;
  assign bus.pc            = r_pc;

  // NOTE: state registers use non-blocking assignments so every branch below
  // reads the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_BOOT;
      r_fetch_pc   <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_kill       <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          if (bus.flush_valid) begin
            r_fetch_pc <= w_flush_pc;
            r_req_addr <= w_flush_pc;
          end
          r_state <= S_REQ;
        end
        S_REQ: begin
          // A request already on the bus is never retracted; its response is
          // marked for discard instead.
          if (bus.flush_valid) begin
            r_fetch_pc <= w_flush_pc;
            r_kill     <= 1'b1;
          end
          if (bus.mem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.flush_valid) begin
            r_fetch_pc <= w_flush_pc;
            if (bus.mem_resp_valid) begin
              r_kill     <= 1'b0;
              r_req_addr <= w_flush_pc;
              r_state    <= S_REQ;
            end else begin
              r_kill <= 1'b1;
            end
          end else if (bus.mem_resp_valid) begin
            if (r_kill) begin
              r_kill     <= 1'b0;
              r_req_addr <= r_fetch_pc;
              r_state    <= S_REQ;
            end else begin
              r_inst       <= bus.mem_resp_data;
              r_pc         <= r_req_addr;
              r_inst_valid <= 1'b1;
              r_state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.flush_valid) begin
            r_fetch_pc   <= w_flush_pc;
            r_req_addr   <= w_flush_pc;
            r_inst_valid <= 1'b0;
            r_state      <= S_REQ;
          end else if (bus.inst_ready) begin
            r_fetch_pc   <= w_next_pc;
            r_req_addr   <= w_next_pc;
            r_inst_valid <= 1'b0;
            r_state      <= S_REQ;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_ifu_fetch.sv
// Self-checking bench for the fetch stage: directed scenarios plus a randomized
// run against a PC-sequence reference model and a one-outstanding memory model.
module tb_ysyx_22050039_ifu_fetch;
  localparam int          XLEN     = 64;
  localparam int          INST_LEN = 32;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22050039_ifu_fetch_if #(.XLEN(XLEN), .INST_LEN(INST_LEN)) bus ();

  ysyx_22050039_ifu_fetch #(.XLEN(XLEN), .INST_LEN(INST_LEN), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model configuration and state.
  int          mem_ready_pct = 100;
  int          mem_lat_min   = 0;
  int          mem_lat_max   = 0;
  bit          mem_const_en  = 1'b1;
  logic [31:0] mem_const     = 32'h0000_0013;
  bit          m_pend        = 1'b0;
  logic [63:0] m_addr        = '0;
  int          m_cnt         = 0;
  int          m_overlap     = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return mem_const_en ? mem_const : (a[31:0] ^ a[63:32] ^ 32'h1357_9BDF);
  endfunction

  // Memory: drives its inputs 1 time unit after each rising edge; a request seen
  // with ready is accepted at the next edge and answered after 0..N idle cycles.
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        m_pend             = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b0;
      end else begin
        bus.mem_resp_valid = 1'b0;
        if (m_pend) begin
          if (m_cnt == 0) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_word(m_addr);
            m_pend             = 1'b0;
          end else begin
            m_cnt--;
          end
        end
        bus.mem_req_ready = (int'($urandom_range(99)) < mem_ready_pct);
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          if (m_pend || bus.mem_resp_valid) m_overlap++;
          m_pend = 1'b1;
          m_addr = bus.mem_req_addr;
          m_cnt  = int'($urandom_range(mem_lat_max, mem_lat_min));
        end
      end
    end
  end

  task automatic test_reset();
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.flush_valid    = 1'b0;
    bus.flush_pc       = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", bus.mem_req_valid); end
    n_tests++; if (bus.mem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h want %h", bus.mem_req_addr, RESET_PC); end
    n_tests++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
    n_tests++; if (bus.inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", bus.inst); end
    n_tests++; if (bus.pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.pc, RESET_PC); end
    rst = 1'b1;
  endtask

  // Zero-wait memory, decode always ready: a 3-cycle REQ/WAIT/HOLD rhythm.
  task automatic test_zero_wait();
    logic [63:0] a;
    bit          exp_req, exp_iv;
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp_req = (i % 3 == 0);
      exp_iv  = (i % 3 == 2);
      a       = RESET_PC + 64'(4 * (i / 3));
      n_tests++; if (bus.mem_req_valid !== exp_req) begin n_fail++; $display("FAIL zw_req_valid c%0d: got %b want %b", i, bus.mem_req_valid, exp_req); end
      if (exp_req) begin
        n_tests++; if (bus.mem_req_addr !== a) begin n_fail++; $display("FAIL zw_req_addr c%0d: got %h want %h", i, bus.mem_req_addr, a); end
      end
      n_tests++; if (bus.inst_valid !== exp_iv) begin n_fail++; $display("FAIL zw_inst_valid c%0d: got %b want %b", i, bus.inst_valid, exp_iv); end
      if (exp_iv) begin
        n_tests++; if (bus.pc !== a) begin n_fail++; $display("FAIL zw_pc c%0d: got %h want %h", i, bus.pc, a); end
        n_tests++; if (bus.inst !== 32'h13) begin n_fail++; $display("FAIL zw_inst c%0d: got %h want 00000013", i, bus.inst); end
      end
    end
  endtask

  // The third fetch is held in HOLD for 5 cycles with decode stalled.
  task automatic test_stall();
    bit          found = 1'b0;
    logic [31:0] inst0;
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin @(negedge clk); found = bus.inst_valid; end
    n_tests++; if (!found) begin n_fail++; $display("FAIL stall_wait_valid: got timeout want inst_valid"); end
    inst0 = bus.inst;
    n_tests++; if (bus.pc !== RESET_PC + 64'd8) begin n_fail++; $display("FAIL stall_pc: got %h want %h", bus.pc, RESET_PC + 64'd8); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL stall_inst_valid c%0d: got %b want 1", k, bus.inst_valid); end
      n_tests++; if (bus.pc !== RESET_PC + 64'd8 || bus.inst !== inst0) begin n_fail++; $display("FAIL stall_hold c%0d: got pc=%h inst=%h want pc=%h inst=%h", k, bus.pc, bus.inst, RESET_PC + 64'd8, inst0); end
      n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_req c%0d: got %b want 0", k, bus.mem_req_valid); end
    end
    bus.inst_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== RESET_PC + 64'd12) begin n_fail++; $display("FAIL stall_next_req: got v=%b a=%h want v=1 a=%h", bus.mem_req_valid, bus.mem_req_addr, RESET_PC + 64'd12); end
  endtask

  // Redirect ignored outside a handshake, honoured (and aligned) on one.
  task automatic test_redirect();
    bit found = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1234_5670;
    for (int k = 0; k < 20 && !found; k++) begin @(negedge clk); found = bus.inst_valid; end
    n_tests++; if (!found || bus.pc !== RESET_PC + 64'd12) begin n_fail++; $display("FAIL redir_pre_pc: got found=%b pc=%h want pc=%h", found, bus.pc, RESET_PC + 64'd12); end
    bus.redirect_pc = 64'h8000_0102;
    bus.inst_ready  = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h8000_0100) begin n_fail++; $display("FAIL redir_req: got v=%b a=%h want v=1 a=0000000080000100", bus.mem_req_valid, bus.mem_req_addr); end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin @(negedge clk); found = bus.inst_valid; end
    n_tests++; if (!found || bus.pc !== 64'h8000_0100 || bus.inst !== 32'h13) begin n_fail++; $display("FAIL redir_deliver: got found=%b pc=%h inst=%h want pc=0000000080000100 inst=00000013", found, bus.pc, bus.inst); end
  endtask

  // Flush during WAIT; the response that follows is dropped.
  task automatic test_flush_wait();
    bit          found = 1'b0;
    logic [31:0] exp_inst;
    mem_lat_min    = 1;
    mem_lat_max    = 1;
    mem_const      = 32'hDEAD_BEEF;
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin @(negedge clk); found = bus.mem_req_valid; end
    n_tests++; if (!found) begin n_fail++; $display("FAIL fw_wait_req: got timeout want mem_req_valid"); end
    @(negedge clk);
    n_tests++; if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL fw_in_wait: got req=%b iv=%b want 0 0", bus.mem_req_valid, bus.inst_valid); end
    bus.flush_valid = 1'b1;
    bus.flush_pc    = 64'h8000_1000;
    @(negedge clk);
    bus.flush_valid = 1'b0;
    n_tests++; if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL fw_after_flush: got req=%b iv=%b want 0 0", bus.mem_req_valid, bus.inst_valid); end
    @(negedge clk);
    n_tests++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL fw_dropped: got iv=%b inst=%h want iv=0", bus.inst_valid, bus.inst); end
    n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h8000_1000) begin n_fail++; $display("FAIL fw_restart: got v=%b a=%h want v=1 a=0000000080001000", bus.mem_req_valid, bus.mem_req_addr); end
    mem_const_en = 1'b0;
    exp_inst     = mem_word(64'h8000_1000);
    found        = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin @(negedge clk); found = bus.inst_valid; end
    n_tests++; if (!found || bus.pc !== 64'h8000_1000 || bus.inst !== exp_inst) begin n_fail++; $display("FAIL fw_deliver: got found=%b pc=%h inst=%h want pc=0000000080001000 inst=%h", found, bus.pc, bus.inst, exp_inst); end
  endtask

  // Flush while a request is stalled by the memory; the request is not retracted.
  task automatic test_flush_req_stall();
    bit          found = 1'b0;
    logic [63:0] a0;
    logic [31:0] exp_inst;
    mem_ready_pct = 0;
    mem_lat_min   = 0;
    mem_lat_max   = 0;
    for (int k = 0; k < 20 && !found; k++) begin @(negedge clk); found = bus.mem_req_valid; end
    a0 = bus.mem_req_addr;
    n_tests++; if (!found || a0 !== 64'h8000_1004) begin n_fail++; $display("FAIL frs_req: got found=%b a=%h want a=0000000080001004", found, a0); end
    bus.flush_valid = 1'b1;
    bus.flush_pc    = 64'h8000_1000;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.flush_valid = 1'b0;
      if (c == 3) mem_ready_pct = 100;
      n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== a0 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL frs_stable c%0d: got v=%b a=%h iv=%b want v=1 a=%h iv=0", c, bus.mem_req_valid, bus.mem_req_addr, bus.inst_valid, a0); end
    end
    @(negedge clk);
    n_tests++; if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL frs_wait: got req=%b iv=%b want 0 0", bus.mem_req_valid, bus.inst_valid); end
    @(negedge clk);
    n_tests++; if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h8000_1000) begin n_fail++; $display("FAIL frs_restart: got iv=%b v=%b a=%h want iv=0 v=1 a=0000000080001000", bus.inst_valid, bus.mem_req_valid, bus.mem_req_addr); end
    exp_inst = mem_word(64'h8000_1000);
    found    = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin @(negedge clk); found = bus.inst_valid; end
    n_tests++; if (!found || bus.pc !== 64'h8000_1000 || bus.inst !== exp_inst) begin n_fail++; $display("FAIL frs_deliver: got found=%b pc=%h inst=%h want pc=0000000080001000 inst=%h", found, bus.pc, bus.inst, exp_inst); end
  endtask

  // PC wrap past the top of the address space, then reset mid-WAIT.
  task automatic test_wrap_and_reset();
    bit found = 1'b0;
    mem_lat_min        = 2;
    mem_lat_max        = 2;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_top_req: got v=%b a=%h want v=1 a=fffffffffffffffc", bus.mem_req_valid, bus.mem_req_addr); end
    for (int k = 0; k < 20 && !found; k++) begin @(negedge clk); found = bus.inst_valid; end
    n_tests++; if (!found || bus.pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_top_pc: got found=%b pc=%h want fffffffffffffffc", found, bus.pc); end
    @(negedge clk);
    n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h0) begin n_fail++; $display("FAIL wrap_zero_req: got v=%b a=%h want v=1 a=0", bus.mem_req_valid, bus.mem_req_addr); end
    @(negedge clk);
    n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_in_wait: got %b want 0", bus.mem_req_valid); end
    rst = 1'b0;
    #1;
    n_tests++; if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL midrst_req: got v=%b a=%h want v=0 a=%h", bus.mem_req_valid, bus.mem_req_addr, RESET_PC); end
    n_tests++; if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.pc !== RESET_PC) begin n_fail++; $display("FAIL midrst_inst: got iv=%b inst=%h pc=%h want 0 0 %h", bus.inst_valid, bus.inst, bus.pc, RESET_PC); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== RESET_PC || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_restart: got v=%b a=%h iv=%b want v=1 a=%h iv=0", bus.mem_req_valid, bus.mem_req_addr, bus.inst_valid, RESET_PC); end
  endtask

  // Random traffic: the model tracks only which PC decode must see next.
  task automatic test_random();
    logic [63:0] exp_pc = RESET_PC;
    logic [63:0] prev_addr = '0;
    bit          prev_stall = 1'b0;
    int          delivered = 0;
    rst           = 1'b0;
    mem_ready_pct = 60;
    mem_lat_min   = 0;
    mem_lat_max   = 3;
    mem_const_en  = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.flush_valid    = 1'b0;
    @(negedge clk);
    m_overlap = 0;
    rst       = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_req_stable c%0d: got v=%b a=%h want v=1 a=%h", cyc, bus.mem_req_valid, bus.mem_req_addr, prev_addr); end
      end
      if (bus.inst_valid === 1'b1) begin
        n_tests++; if (bus.pc !== exp_pc || bus.inst !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_deliver c%0d: got pc=%h inst=%h want pc=%h inst=%h", cyc, bus.pc, bus.inst, exp_pc, mem_word(exp_pc)); end
      end
      prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
      prev_addr  = bus.mem_req_addr;
      bus.flush_valid    = ($urandom_range(19) == 0);
      bus.flush_pc       = {$urandom, $urandom};
      bus.redirect_valid = ($urandom_range(2) == 0);
      bus.redirect_pc    = {$urandom, $urandom};
      bus.inst_ready     = $urandom_range(1) == 1;
      if (bus.flush_valid) begin
        exp_pc = bus.flush_pc & ~64'd3;
      end else if (bus.inst_valid && bus.inst_ready) begin
        exp_pc = bus.redirect_valid ? (bus.redirect_pc & ~64'd3) : (exp_pc + 64'd4);
        delivered++;
      end
    end
    bus.flush_valid    = 1'b0;
    bus.redirect_valid = 1'b0;
    n_tests++; if (delivered < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d transfers want >= 100", delivered); end
    n_tests++; if (m_overlap !== 0) begin n_fail++; $display("FAIL rnd_one_outstanding: got %0d overlaps want 0", m_overlap); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect();
    test_flush_wait();
    test_flush_req_stall();
    test_wrap_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
